// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Purpose:
//   Raster timing generator for a pixel-clocked display. A pair of free-running
//   counters walks the full frame (visible + porches + sync). The current
//   counts are published to colour sources, which answer with a pixel colour
//   PIXEL_DELAY clocks later. The sync/data-enable flags derived from the
//   counts are pushed through a matching delay line, so that the final output
//   register combines the timing and the colour that belong to the same counts.
//
// Handshake / timing contract (single clock domain, no backpressure):
//   counts presented in cycle t  -> source returns ext_color in cycle t+PIXEL_DELAY
//                                -> vga_* reflect those counts in cycle t+PIXEL_DELAY+1
//   frame_start / line_start are aligned with ext_count_* (undelayed).
//
// Ports:
//   clk          in   pixel clock
//   reset_n      in   synchronous active-low reset
//   ext_count_h  out  current horizontal count (32-bit signed, never negative)
//   ext_count_v  out  current vertical count   (32-bit signed, never negative)
//   ext_color    in   colour from the source, PIXEL_DELAY clocks after its counts
//   frame_start  out  one-clock pulse while (0,0) is presented
//   line_start   out  one-clock pulse while count_h==0 is presented
//   vga_hs       out  horizontal sync, level SYNC_POL when active
//   vga_vs       out  vertical sync, level SYNC_POL when active
//   vga_de       out  data enable
//   vga_color    out  pixel colour, 0 outside the visible area
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int BPP         = 8,
  parameter int PIXEL_DELAY = 8,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic signed [31:0]  ext_count_h,
  output logic signed [31:0]  ext_count_v,
  input  logic [BPP-1:0]      ext_color,
  output logic                frame_start,
  output logic                line_start,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_de,
  output logic [BPP-1:0]      vga_color
);

  // ---------------------------------------------------------------------------
  // Frame geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int HW = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Region boundaries, compared in 32 bits so that a boundary equal to the
  // total (e.g. zero-width porches) cannot overflow the counter width.
  localparam logic [31:0] H_VIS_END  = 32'(H_VISIBLE);
  localparam logic [31:0] H_SYNC_BEG = 32'(H_VISIBLE + H_FP);
  localparam logic [31:0] H_SYNC_END = 32'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [31:0] V_VIS_END  = 32'(V_VISIBLE);
  localparam logic [31:0] V_SYNC_BEG = 32'(V_VISIBLE + V_FP);
  localparam logic [31:0] V_SYNC_END = 32'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic SYNC_IDLE = ~SYNC_POL;

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  logic [HW-1:0] r_count_h;
  logic [VW-1:0] r_count_v;
  logic          r_started;     // 0 while in reset and on the release edge
  logic          r_frame_start;
  logic          r_line_start;

  logic [HW-1:0] w_next_h;
  logic [VW-1:0] w_next_v;
  logic          w_h_wrap;
  logic          w_v_wrap;

  always_comb begin
    w_h_wrap = (r_count_h == H_LAST);
    w_v_wrap = (r_count_v == V_LAST);
    w_next_h = w_h_wrap ? '0 : r_count_h + HW'(1);
    w_next_v = r_count_v;
    if (w_h_wrap) begin
      w_next_v = w_v_wrap ? '0 : r_count_v + VW'(1);
    end
  end

  // The first edge after reset releases holds the counters at (0,0) and
  // raises the start pulses, so (0,0) is the first position presented and
  // it is presented together with frame_start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count_h     <= '0;
      r_count_v     <= '0;
      r_started     <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else if (!r_started) begin
      r_count_h     <= '0;
      r_count_v     <= '0;
      r_started     <= 1'b1;
      r_frame_start <= 1'b1;
      r_line_start  <= 1'b1;
    end else begin
      r_count_h     <= w_next_h;
      r_count_v     <= w_next_v;
      r_frame_start <= (w_next_h == '0) && (w_next_v == '0);
      r_line_start  <= (w_next_h == '0);
    end
  end

  logic [31:0] w_h32;
  logic [31:0] w_v32;

  assign w_h32 = {{(32-HW){1'b0}}, r_count_h};
  assign w_v32 = {{(32-VW){1'b0}}, r_count_v};

  assign ext_count_h = $signed(w_h32);
  assign ext_count_v = $signed(w_v32);
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

  // ---------------------------------------------------------------------------
  // Undelayed timing flags, decoded from the presented counts. They are gated
  // by r_started so the reset-held (0,0) never enters the delay line as a
  // visible pixel.
  // ---------------------------------------------------------------------------
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_de_raw;

  always_comb begin
    w_hs_raw = r_started && (w_h32 >= H_SYNC_BEG) && (w_h32 < H_SYNC_END);
    w_vs_raw = r_started && (w_v32 >= V_SYNC_BEG) && (w_v32 < V_SYNC_END);
    w_de_raw = r_started && (w_h32 < H_VIS_END) && (w_v32 < V_VIS_END);
  end

  // ---------------------------------------------------------------------------
  // Delay line matching the colour-source latency. Index PIXEL_DELAY-1 holds
  // the flags for the counts whose colour is on ext_color this cycle. Reset
  // clears every stage, so no half-finished sync pulse survives a restart.
  // ---------------------------------------------------------------------------
  logic [PIXEL_DELAY-1:0] r_hs_dly;
  logic [PIXEL_DELAY-1:0] r_vs_dly;
  logic [PIXEL_DELAY-1:0] r_de_dly;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hs_dly <= '0;
      r_vs_dly <= '0;
      r_de_dly <= '0;
    end else begin
      r_hs_dly[0] <= w_hs_raw;
      r_vs_dly[0] <= w_vs_raw;
      r_de_dly[0] <= w_de_raw;
      for (int i = 1; i < PIXEL_DELAY; i++) begin
        r_hs_dly[i] <= r_hs_dly[i-1];
        r_vs_dly[i] <= r_vs_dly[i-1];
        r_de_dly[i] <= r_de_dly[i-1];
      end
    end
  end

  logic w_hs_d;
  logic w_vs_d;
  logic w_de_d;

  assign w_hs_d = r_hs_dly[PIXEL_DELAY-1];
  assign w_vs_d = r_vs_dly[PIXEL_DELAY-1];
  assign w_de_d = r_de_dly[PIXEL_DELAY-1];

  // ---------------------------------------------------------------------------
  // Output stage: all four vga_* outputs are registered here together, so
  // they share one latency. ext_color is only sampled while delayed de is set.
  // ---------------------------------------------------------------------------
  logic           r_vga_hs;
  logic           r_vga_vs;
  logic           r_vga_de;
  logic [BPP-1:0] r_vga_color;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vga_hs    <= SYNC_IDLE;
      r_vga_vs    <= SYNC_IDLE;
      r_vga_de    <= 1'b0;
      r_vga_color <= '0;
    end else begin
      r_vga_hs    <= w_hs_d ? SYNC_POL : SYNC_IDLE;
      r_vga_vs    <= w_vs_d ? SYNC_POL : SYNC_IDLE;
      r_vga_de    <= w_de_d;
      r_vga_color <= w_de_d ? ext_color : '0;
    end
  end

  assign vga_hs    = r_vga_hs;
  assign vga_vs    = r_vga_vs;
  assign vga_de    = r_vga_de;
  assign vga_color = r_vga_color;

endmodule
